// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read controller re-presenting words on a valid/ready stream
module fifo_stream_reader #(
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 8,
  localparam int BEAT_W     = $clog2(BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rden,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  burst_done,
  output logic [BEAT_W-1:0]     beat_cnt
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  // reads issued to the FIFO and not yet popped downstream (0..2)
  logic [1:0]            out_cnt;
  logic [1:0]            cnt_after_pop;
  // a read was accepted last cycle, so fifo_rdata holds a real word now
  logic                  rd_pend;
  // two-entry skid buffer
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;
  logic                  pop;

  assign pop           = m_valid & m_ready;
  assign cnt_after_pop = out_cnt - {1'b0, pop};

  // Gated by rst_n so the request cannot glitch high while reset is held.
  assign fifo_rden = rst_n & en & ~fifo_empty & (cnt_after_pop < 2'd2);

  assign m_valid = (occ != 2'd0);
  assign m_data  = buf_q[rd_ptr];
  assign m_last  = m_valid & (beat_cnt == LAST_BEAT);

  // Track outstanding reads and remember which cycle returns FIFO data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= 2'd0;
      rd_pend <= 1'b0;
    end else begin
      out_cnt <= out_cnt + {1'b0, fifo_rden} - {1'b0, pop};
      rd_pend <= fifo_rden;
    end
  end

  // Skid buffer: capture the returning word at the tail, release the head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
    end else begin
      if (rd_pend) begin
        buf_q[wr_ptr] <= fifo_rdata;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  // Count accepted beats within a burst and flag the beat after the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= pop & m_last;
      if (pop) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
      end
    end
  end

  // A word arriving into a full buffer with no pop would be lost.
  assert property (@(posedge clk) disable iff (!rst_n) !(rd_pend && !pop && occ == 2'd2));
  // Outstanding reads never exceed the buffer depth.
  assert property (@(posedge clk) disable iff (!rst_n) out_cnt <= 2'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader with a FIFO model
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rden;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          burst_done;
  logic [2:0]    beat_cnt;

  // FIFO model: combinational empty, registered read data, zero when no read
  logic [7:0]    fmem [256];
  logic [7:0]    wr_idx = 8'd0;
  logic [7:0]    rd_idx = 8'd0;

  int            errors = 0;
  int            checks = 0;
  int            n_rden = 0;
  int            n_pop = 0;
  int            n_done = 0;
  int            max_out = 0;
  logic [7:0]    exp_q [$];

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rden  (fifo_rden),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .burst_done (burst_done),
    .beat_cnt   (beat_cnt)
  );

  initial forever #5 clk = ~clk;

  assign fifo_empty = (rd_idx == wr_idx);

  // FIFO read port; reset flushes it alongside the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx     <= wr_idx;
      fifo_rdata <= '0;
    end else if (fifo_rden) begin
      fifo_rdata <= fmem[rd_idx];
      rd_idx     <= rd_idx + 8'd1;
    end else begin
      fifo_rdata <= '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr_idx] = d;
    wr_idx = wr_idx + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < 400) begin
      tick();
      k++;
    end
    chk({name, "_drain_timeout"}, (k < 400), 1);
    tick();
    tick();
    chk({name, "_scoreboard_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: compares every pop against the scoreboard and models beat/last/done
  initial begin
    int          exp_beat;
    logic        exp_done;
    logic        prev_stall;
    logic [7:0]  prev_data;
    logic [7:0]  d;
    exp_beat   = 0;
    exp_done   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_beat   = 0;
        exp_done   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        chk("beat_cnt", beat_cnt, exp_beat);
        chk("m_last", m_last, (m_valid && exp_beat == BL - 1));
        chk("burst_done", burst_done, exp_done);
        if (fifo_rden && fifo_empty) chk("rden_while_empty", 1, 0);
        if (prev_stall) begin
          chk("stall_valid_hold", m_valid, 1);
          chk("stall_data_hold", m_data, prev_data);
        end
        if (fifo_rden) n_rden++;
        if (burst_done) n_done++;
        if (int'(dut.out_cnt) > max_out) max_out = int'(dut.out_cnt);
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (m_valid && m_ready) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            chk("unexpected_pop", 1, 0);
          end else begin
            d = exp_q.pop_front();
            chk("m_data", m_data, d);
          end
          exp_done = (exp_beat == BL - 1);
          exp_beat = (exp_beat == BL - 1) ? 0 : exp_beat + 1;
        end else begin
          exp_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rden0;
    int pop0;
    int done0;
    int run;
    int k;

    // Reset, FIFO empty, en=1, m_ready=1
    en = 1'b1;
    m_ready = 1'b1;
    tick();
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_rden", fifo_rden, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_rden", fifo_rden, 0);
      chk("idle_outputs", {m_valid, m_data, m_last, burst_done, beat_cnt}, 0);
      tick();
    end

    // Streaming 0x00..0x0F
    en = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    done0 = n_done;
    tick();
    en = 1'b1;
    @(negedge clk);
    chk("stream_first_rden", fifo_rden, 1);
    tick();
    @(negedge clk);
    chk("stream_valid_n1", m_valid, 0);
    tick();
    @(negedge clk);
    chk("stream_valid_n2", m_valid, 1);
    chk("stream_first_word", m_data, 8'h00);
    run = 1;
    for (int i = 1; i < 16; i++) begin
      tick();
      @(negedge clk);
      if (m_valid) run++;
    end
    chk("stream_consecutive_pops", run, 16);
    drain("stream");
    chk("stream_burst_done_count", n_done - done0, 2);

    // Backpressure: 8 words, m_ready low for 10 cycles
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
    rden0 = n_rden;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk("bp_valid_held", m_valid, 1);
        chk("bp_word0_held", m_data, 8'h20);
      end
      tick();
    end
    chk("bp_rden_count", n_rden - rden0, 2);
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bp_release_no_gap", m_valid, 1);
      tick();
    end
    drain("bp");

    // Random m_ready over 64 words including zeros
    for (int i = 0; i < 64; i++) push((i % 4 == 0) ? 8'h00 : 8'((i * 37) & 255));
    pop0 = n_pop;
    k = 0;
    while ((n_pop - pop0) < 64 && k < 3000) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      k++;
    end
    chk("rand_timeout", (k < 3000), 1);
    tick();
    m_ready = 1'b1;
    drain("rand");
    chk("rand_out_cnt_max", (max_out <= 2), 1);

    // Enable drop after two reads
    en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i));
    tick();
    rden0 = n_rden;
    pop0 = n_pop;
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("en_drop_idle_valid", m_valid, 0);
    tick();
    chk("en_drop_rden_count", n_rden - rden0, 2);
    chk("en_drop_pop_count", n_pop - pop0, 2);
    chk("en_drop_fifo_kept", fifo_empty, 0);
    en = 1'b1;
    drain("en_drop");
    chk("en_drop_total_pops", n_pop - pop0, 6);

    // Reset mid-stream
    for (int i = 0; i < 12; i++) push(8'h60 + 8'(i));
    pop0 = n_pop;
    k = 0;
    while ((n_pop - pop0) < 3 && k < 100) begin
      tick();
      @(negedge clk);
      k++;
    end
    chk("mid_reset_pre_valid", m_valid, 1);
    chk("mid_reset_pre_rd_pend", dut.rd_pend, 1);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_reset_outputs", {fifo_rden, m_valid, m_data, m_last, burst_done, beat_cnt}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_beat", beat_cnt, 0);
    chk("post_reset_valid", m_valid, 0);
    tick();
    pop0 = n_pop;
    push(8'h00);
    push(8'h71);
    push(8'h72);
    drain("post_reset");
    chk("post_reset_pops", n_pop - pop0, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
